// File: rtl/uart_rtl_core.sv
// 8N1 UART transceiver: free-running 16x oversample tick shared by an independent
// transmit FSM and a mid-bit sampling receive FSM behind a 2-flop synchroniser.
`timescale 1ns/1ps
module uart_rtl_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk_tb,
    input  logic       reset_tb,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       irq
);

    localparam int TW = $clog2(DIV);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] DIV_LAST = TW'(DIV - 1);
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [TW-1:0] div_q;
    logic          tick;

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // ---------------- transmitter ----------------
    state_t        tx_state_q, tx_state_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [OW-1:0] tx_tick_q,  tx_tick_d;
    logic [2:0]    tx_bit_q,   tx_bit_d;

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            tx_state_q <= IDLE;
            tx_shift_q <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx         = 1'b1;
        busy       = 1'b1;
        case (tx_state_q)
            IDLE: begin
                busy = 1'b0;
                if (transmit) begin
                    tx_shift_d = tx_byte;
                    tx_tick_d  = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    tx_tick_d = tx_tick_q + 1'b1;
                    if (tx_tick_q == OS_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = DATA;
                    end
                end
            end
            DATA: begin
                tx = tx_shift_q[0];
                if (tick) begin
                    tx_tick_d = tx_tick_q + 1'b1;
                    if (tx_tick_q == OS_LAST) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick && tx_tick_q == OS_LAST) begin
                    tx_tick_d  = '0;
                    tx_state_d = IDLE;
                end else if (tick) begin
                    tx_tick_d = tx_tick_q + 1'b1;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    // ---------------- receiver ----------------
    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev_q;
    state_t        rx_state_q, rx_state_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [OW-1:0] rx_tick_q,  rx_tick_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_byte_q,  rx_byte_d;
    logic          irq_q,      irq_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_tb or negedge reset_tb) begin
        if (!reset_tb) begin
            sync_q     <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_shift_q <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_byte_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_byte_q  <= rx_byte_d;
            irq_q      <= irq_d;
        end
    end

    // A framing error drops straight back to IDLE: the edge detector needs the
    // line to go high again before a new start bit can be recognised.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_byte_d  = rx_byte_q;
        irq_d      = 1'b0;
        case (rx_state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_tick_d  = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 1'b1;
                    if (rx_tick_q == OS_MID) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 1'b1;
                    if (rx_tick_q == OS_LAST) begin
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 1'b1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 1'b1;
                    if (rx_tick_q == OS_LAST) begin
                        rx_state_d = IDLE;
                        if (rx_s) begin
                            rx_byte_d = rx_shift_q;
                            irq_d     = 1'b1;
                        end
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign rx_byte = rx_byte_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rtl_core.sv
// Bench for uart_rtl_core: far-end frame driver and tx-line decoder feeding
// expected-byte queues, a table of receive vectors and hand-written corner cases.
`timescale 1ns/1ps
module tb_uart_rtl_core;

    localparam int BIT_CLKS = 432;

    logic       clk_tb   = 1'b0;
    logic       reset_tb = 1'b0;
    logic       rx_bfm   = 1'b1;
    logic       loop_en  = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] tx_byte  = 8'h00;
    logic       rx_line;
    logic       tx;
    logic       busy;
    logic [7:0] rx_byte;
    logic       irq;

    assign rx_line = loop_en ? tx : rx_bfm;

    uart_rtl_core dut (
        .clk_tb   (clk_tb),
        .reset_tb (reset_tb),
        .rx       (rx_line),
        .tx       (tx),
        .transmit (transmit),
        .tx_byte  (tx_byte),
        .busy     (busy),
        .rx_byte  (rx_byte),
        .irq      (irq)
    );

    always #10 clk_tb = ~clk_tb;

    int         tests     = 0;
    int         fails     = 0;
    int         irq_count = 0;
    bit         mon_en    = 1'b1;
    bit         rxb_bad   = 1'b0;
    logic [7:0] rxb_prev  = 8'h00;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bclks;
        logic       good;
        logic [7:0] exp_rxb;
    } rx_vec_t;

    rx_vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop, input int bclks);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_bfm = f[k];
            repeat (bclks) @(negedge clk_tb);
        end
        rx_bfm = 1'b1;
    endtask

    task automatic wait_not_busy();
        int n;
        n = 0;
        while (busy && n < 10000) begin
            @(negedge clk_tb);
            n++;
        end
        if (busy) check("busy timeout", busy, 1'b0);
    endtask

    task automatic send_tx(input logic [7:0] b, input bit push);
        wait_not_busy();
        tx_byte  = b;
        transmit = 1'b1;
        @(negedge clk_tb);
        transmit = 1'b0;
        check("accept busy", busy, 1'b1);
        check("accept tx start", tx, 1'b0);
        if (push) tx_exp.push_back(b);
    endtask

    // Receive-side scoreboard: every irq must match the oldest expected byte.
    initial forever begin
        @(negedge clk_tb);
        if (!reset_tb) begin
            rxb_prev = rx_byte;
        end else begin
            if (irq) begin
                irq_count++;
                if (rx_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected irq: rx_byte %0h, none required", rx_byte);
                end else begin
                    check("rx_byte at irq", rx_byte, rx_exp.pop_front());
                end
            end else if (rx_byte !== rxb_prev) begin
                rxb_bad = 1'b1;
            end
            rxb_prev = rx_byte;
        end
    end

    // Far-end 16550 model on the tx line: mid-bit sampling at the nominal rate.
    logic [7:0] mon_d;
    logic       mon_st, mon_sp;
    initial forever begin
        @(negedge clk_tb);
        if (mon_en && reset_tb && tx === 1'b0) begin
            repeat (BIT_CLKS / 2) @(negedge clk_tb);
            mon_st = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk_tb);
                mon_d[i] = tx;
            end
            repeat (BIT_CLKS) @(negedge clk_tb);
            mon_sp = tx;
            if (mon_en) begin
                check("tx start bit", mon_st, 1'b0);
                check("tx stop bit", mon_sp, 1'b1);
                if (tx_exp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected tx frame: actual %0h, none required", mon_d);
                end else begin
                    check("tx byte", mon_d, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         irq_before;
        logic [9:0] frame;

        vecs[0] = '{data: 8'h58, stop: 1'b1, bclks: 432, good: 1'b1, exp_rxb: 8'h58};
        vecs[1] = '{data: 8'h59, stop: 1'b1, bclks: 432, good: 1'b1, exp_rxb: 8'h59};
        vecs[2] = '{data: 8'h5A, stop: 1'b1, bclks: 432, good: 1'b1, exp_rxb: 8'h5A};
        vecs[3] = '{data: 8'h55, stop: 1'b0, bclks: 432, good: 1'b0, exp_rxb: 8'h5A};
        vecs[4] = '{data: 8'hA5, stop: 1'b1, bclks: 432, good: 1'b1, exp_rxb: 8'hA5};
        vecs[5] = '{data: 8'h3C, stop: 1'b1, bclks: 441, good: 1'b1, exp_rxb: 8'h3C};
        vecs[6] = '{data: 8'hC3, stop: 1'b1, bclks: 423, good: 1'b1, exp_rxb: 8'hC3};

        // Reset state
        reset_tb = 1'b0;
        #200;
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset irq", irq, 1'b0);
        check("reset rx_byte", rx_byte, 8'h00);
        @(negedge clk_tb);
        reset_tb = 1'b1;
        repeat (5) @(negedge clk_tb);

        // Receive vectors: nominal, framing error, +/-2 % far-end rate
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].good) rx_exp.push_back(vecs[i].data);
            send_rx(vecs[i].data, vecs[i].stop, vecs[i].bclks);
            repeat (20) @(negedge clk_tb);
            check($sformatf("rx vec %0d rx_byte", i), rx_byte, vecs[i].exp_rxb);
        end
        check("rx queue drained", rx_exp.size(), 0);

        // Transmit 0x41 with bit-level check; a request while busy is dropped
        tx_byte  = 8'h41;
        transmit = 1'b1;
        @(negedge clk_tb);
        transmit = 1'b0;
        check("A accept busy", busy, 1'b1);
        check("A accept tx", tx, 1'b0);
        tx_exp.push_back(8'h41);
        frame = {1'b1, 8'h41, 1'b0};
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? 200 : BIT_CLKS) @(negedge clk_tb);
            cnt += (k == 0) ? 200 : BIT_CLKS;
            check($sformatf("A bit %0d", k), tx, frame[k]);
        end
        tx_byte  = 8'h43;
        transmit = 1'b1;
        @(negedge clk_tb);
        transmit = 1'b0;
        cnt++;
        while (busy && cnt < 5000) begin
            @(negedge clk_tb);
            cnt++;
        end
        check("A busy length 4290..4322", (cnt >= 4290 && cnt <= 4322), 1'b1);
        repeat (5) @(negedge clk_tb);
        check("request while busy not queued", busy, 1'b0);

        // Back-to-back 0x42, 0x43
        send_tx(8'h42, 1'b1);
        send_tx(8'h43, 1'b1);
        wait_not_busy();
        repeat (10) @(negedge clk_tb);
        check("tx queue drained", tx_exp.size(), 0);

        // 100 ns glitch on rx
        irq_before = irq_count;
        rx_bfm = 1'b0;
        #100;
        rx_bfm = 1'b1;
        repeat (1000) @(negedge clk_tb);
        check("glitch no irq", irq_count, irq_before);

        // Loopback 0x00 and 0xFF
        loop_en = 1'b1;
        repeat (5) @(negedge clk_tb);
        irq_before = irq_count;
        rx_exp.push_back(8'h00);
        send_tx(8'h00, 1'b1);
        rx_exp.push_back(8'hFF);
        send_tx(8'hFF, 1'b1);
        wait_not_busy();
        repeat (50) @(negedge clk_tb);
        check("loopback irq count", irq_count, irq_before + 2);
        check("loopback rx_byte", rx_byte, 8'hFF);
        check("loopback rx queue", rx_exp.size(), 0);
        check("loopback tx queue", tx_exp.size(), 0);

        // Asynchronous reset in the middle of a frame
        loop_en = 1'b0;
        mon_en  = 1'b0;
        send_tx(8'h00, 1'b0);
        repeat (1000) @(negedge clk_tb);
        check("mid-frame tx low", tx, 1'b0);
        #5;
        reset_tb = 1'b0;
        #1;
        check("async reset tx", tx, 1'b1);
        check("async reset busy", busy, 1'b0);
        #100;
        check("async reset rx_byte", rx_byte, 8'h00);
        @(negedge clk_tb);
        reset_tb = 1'b1;
        repeat (5) @(negedge clk_tb);
        check("rx_byte only changes with irq", rxb_bad, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rtl_core.md
# uart_rtl_core

Full-duplex 8N1 UART transceiver with a byte-wide parallel interface, clocked from the 50 MHz system clock. A single `transmit` strobe serialises `tx_byte` on `tx`, with `busy` as flow control. The receiver samples `rx` at 16x oversampling, presents each good byte on `rx_byte` and pulses `irq`. The block sits between on-chip logic and the external serial pins, and talks to a standard 16550-class UART at the far end of the cable.

## Interface
Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, receive ticks per bit.
- DIV, CLK_HZ/(BAUD*OVERSAMPLE) = 27 (integer division), clocks per oversample tick.

Ports:
- clk_tb  input  1  clock; all logic on the rising edge.
- reset_tb  input  1  reset, asynchronous, active-low.
- rx  input  1  serial receive line; idle high; asynchronous to clk_tb.
- tx  output  1  serial transmit line; idle high.
- transmit  input  1  one-cycle (or longer) request to send tx_byte.
- tx_byte  input  8  byte to send; sampled only when a request is accepted.
- busy  output  1  transmitter occupied; requests ignored while high.
- rx_byte  output  8  last correctly received byte; holds until the next good byte.
- irq  output  1  one-cycle pulse when rx_byte is updated.

## Operation
- Tick generator: free-running counter 0..DIV-1 that produces a 1-cycle tick at wrap. Transmit and receive share it. A bit period is OVERSAMPLE ticks (432 clocks at defaults, about 115741 baud, +0.47 % error).
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If transmit=1, latch tx_byte into the shift register, then go to START and set busy=1.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: tx=shift[0], shifting right after each bit period, 8 bits with a 3-bit counter. Then go to STOP.
  - STOP: tx=1 for one bit period, then go to IDLE with busy=0.
  - transmit while busy=1 is ignored and not queued. transmit held high at the end of a frame starts a new frame back-to-back.
- RX path: rx passes through a 2-flop synchroniser (reset value 1) before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a synchronised falling edge (1 then 0), go to START and clear the tick count.
  - START: at tick 7 (mid-bit), if the line is still 0, go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA: sample at every 16th tick thereafter (mid-bit), shifting in LSB first, 8 bits.
  - STOP: sample mid-bit. If 1, load rx_byte and pulse irq for one cycle, then go to IDLE. If 0, it is a framing error: discard the byte, no irq, and wait for the line to return high before re-arming in IDLE.
- TX and RX are fully independent; simultaneous activity is allowed. Loopback of tx to rx must recover the transmitted byte.

## Timing
- Reset values while reset_tb=0: tx=1, busy=0, irq=0, rx_byte=8'h00, both FSMs IDLE, tick counter 0, synchroniser=1.
- Reset is asynchronous: mid-frame it drives tx high and drops busy immediately. Any partial RX byte is lost.
- TX accept: transmit sampled high at edge N with busy=0 gives busy=1 and tx=0 after edge N. The start-bit length is up to one tick short, because tick phase is free-running.
- busy falls at the end of the stop bit, about 10 x 432 = 4320 clocks after acceptance. transmit at that same cycle is accepted.
- RX latency: irq and the rx_byte update occur about 2 clocks (synchroniser) after the mid-stop-bit sample, about 9.5 bit periods after the start edge.
- irq is exactly one clk_tb cycle wide per good byte. rx_byte changes only in that cycle.
- Tolerance: reception must succeed with a far-end baud error of ±2 %.

## Test plan
- Reset: hold reset_tb=0 for 200 ns -> tx=1, busy=0, irq=0, rx_byte=00. Assert reset mid-transmit -> tx=1 and busy=0 immediately.
- TX "A": pulse transmit with tx_byte=8'h41 -> bits 0,1,0,0,0,0,0,1,0,1 on tx at 432 clocks/bit. busy is high for about 4320 clocks. A 16550 set to 115200 8N1 reads 0x41.
- Back-to-back "B","C": issue transmit while busy for 0x43 -> ignored. Issue 0x42 then 0x43 after busy falls -> the far end receives 0x42 then 0x43 in order.
- RX "X","Y","Z": far-end 16550 sends 0x58, 0x59, 0x5A -> exactly three irq pulses, with rx_byte = 58, 59, 5A respectively.
- Framing error: drive a frame of 0x55 with the stop bit at 0 -> no irq and rx_byte unchanged. The next valid frame of 0xA5 is received correctly.
- Glitch and loopback: a 100 ns low pulse on rx -> no irq. With tx tied to rx, sending 0x00 and 0xFF returns the same values with one irq each.
